// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: priority/aging grant, registered write, forwarding.
// Optional macro RF_WB_ARB_AGING_EN enables wait counters and starvation promotion.
module rf_wb_arbiter #(
   parameter int unsigned NUM_SRC  = 3,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_SRC-1:0]      src_valid,
   output logic [NUM_SRC-1:0]      src_ready,
   input  logic [5*NUM_SRC-1:0]    src_waddr,
   input  logic [32*NUM_SRC-1:0]   src_wdata,
   output logic                    rf_wen,
   output logic [4:0]              rf_waddr,
   output logic [31:0]             rf_wdata,
   input  logic [4:0]              raddr1,
   input  logic [4:0]              raddr2,
   output logic                    fwd_hit1,
   output logic                    fwd_hit2,
   output logic [31:0]             fwd_data1,
   output logic [31:0]             fwd_data2
);

   if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
      $error("rf_wb_arbiter: NUM_SRC must be in 2..8");
   end
   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("rf_wb_arbiter: MAX_WAIT must be in 1..15");
   end

   logic [NUM_SRC-1:0] starving;
   logic [NUM_SRC-1:0] grant;
   logic               xfer;
   logic [4:0]         sel_waddr;
   logic [31:0]        sel_wdata;

   logic               rf_wen_q;
   logic [4:0]         rf_waddr_q;
   logic [31:0]        rf_wdata_q;

`ifdef RF_WB_ARB_AGING_EN
   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   logic [3:0] wait_cnt_q [NUM_SRC];
   logic [3:0] wait_cnt_d [NUM_SRC];

   always_comb begin
      starving = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         starving[i] = src_valid[i] && (wait_cnt_q[i] == MaxWait);
      end
   end

   // Granted or idle sources restart their wait; others age up to the threshold.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         wait_cnt_d[i] = wait_cnt_q[i];
         if (!src_valid[i] || grant[i]) begin
            wait_cnt_d[i] = 4'd0;
         end else if (wait_cnt_q[i] != MaxWait) begin
            wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (reset) begin
            wait_cnt_q[i] <= 4'd0;
         end else begin
            wait_cnt_q[i] <= wait_cnt_d[i];
         end
      end
   end
`else
   assign starving = '0;
`endif

   // Starving sources first, then plain fixed priority; nothing is granted during reset.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!found && starving[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!found && src_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      if (reset) begin
         grant = '0;
      end
   end

   assign src_ready = grant;
   assign xfer      = |grant;

   // Grant is one-hot, so an OR-reduction acts as the data mux.
   always_comb begin
      sel_waddr = 5'd0;
      sel_wdata = 32'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            sel_waddr = sel_waddr | src_waddr[5*i +: 5];
            sel_wdata = sel_wdata | src_wdata[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= 5'd0;
         rf_wdata_q <= 32'd0;
      end else begin
         rf_wen_q <= xfer && (sel_waddr != 5'd0);
         if (xfer) begin
            rf_waddr_q <= sel_waddr;
            rf_wdata_q <= sel_wdata;
         end
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

   assign fwd_hit1  = rf_wen_q && (rf_waddr_q == raddr1) && (raddr1 != 5'd0);
   assign fwd_hit2  = rf_wen_q && (rf_waddr_q == raddr2) && (raddr2 != 5'd0);
   assign fwd_data1 = fwd_hit1 ? rf_wdata_q : 32'd0;
   assign fwd_data2 = fwd_hit2 ? rf_wdata_q : 32'd0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NUM_SRC=3, MAX_WAIT=4).
// Aging checks follow the RF_WB_ARB_AGING_EN build setting.
module tb_rf_wb_arbiter;

   logic         clk;
   logic         reset;
   logic [2:0]   src_valid;
   logic [2:0]   src_ready;
   logic [14:0]  src_waddr;
   logic [95:0]  src_wdata;
   logic         rf_wen;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;
   logic [4:0]   raddr1;
   logic [4:0]   raddr2;
   logic         fwd_hit1;
   logic         fwd_hit2;
   logic [31:0]  fwd_data1;
   logic [31:0]  fwd_data2;

   int total = 0;
   int bad   = 0;
   int g0;
   int g2;

   logic [31:0] rf_model [32];

   rf_wb_arbiter #(
      .NUM_SRC  (3),
      .MAX_WAIT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_waddr (src_waddr),
      .src_wdata (src_wdata),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file commits whatever the arbiter presents at the next edge.
   always @(posedge clk) begin
      if (rf_wen) rf_model[rf_waddr] <= rf_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
      src_waddr[5*i +: 5]   = a;
      src_wdata[32*i +: 32] = d;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;
      reset     = 1'b1;
      src_valid = 3'b111;
      src_waddr = '0;
      src_wdata = '0;
      raddr1    = 5'd0;
      raddr2    = 5'd0;
      set_src(0, 5'd3, 32'h1111_1111);
      set_src(1, 5'd4, 32'h2222_2222);
      set_src(2, 5'd6, 32'h3333_3333);

      // Reset held 3 cycles with every source requesting
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("reset_ready", 32'(src_ready), 32'h0);
         @(posedge clk);
         #1;
         chk("reset_wen", 32'(rf_wen), 32'h0);
      end
      chk("reset_waddr", 32'(rf_waddr), 32'h0);
      chk("reset_wdata", rf_wdata, 32'h0);
      chk("reset_fwd_hit1", 32'(fwd_hit1), 32'h0);
      chk("reset_fwd_data2", fwd_data2, 32'h0);

      // Pending request survives reset and is granted right after
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_reset_ready", 32'(src_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("post_reset_wen", 32'(rf_wen), 32'h1);
      chk("post_reset_waddr", 32'(rf_waddr), 32'd3);
      chk("post_reset_wdata", rf_wdata, 32'h1111_1111);

      // Lone src1 write with forwarding
      @(negedge clk);
      src_valid = 3'b010;
      set_src(1, 5'd5, 32'hDEAD_BEEF);
      raddr1 = 5'd4;
      raddr2 = 5'd5;
      #1;
      chk("single_ready", 32'(src_ready), 32'h2);
      @(posedge clk);
      #1;
      chk("single_wen", 32'(rf_wen), 32'h1);
      chk("single_waddr", 32'(rf_waddr), 32'd5);
      chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk("single_hit2", 32'(fwd_hit2), 32'h1);
      chk("single_fwd2", fwd_data2, 32'hDEAD_BEEF);
      chk("single_hit1", 32'(fwd_hit1), 32'h0);
      chk("single_fwd1", fwd_data1, 32'h0);

      // Idle cycle: enable drops, address/data hold
      @(negedge clk);
      src_valid = 3'b000;
      #1;
      chk("idle_ready", 32'(src_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("idle_wen", 32'(rf_wen), 32'h0);
      chk("idle_waddr_hold", 32'(rf_waddr), 32'd5);
      chk("idle_wdata_hold", rf_wdata, 32'hDEAD_BEEF);
      chk("idle_hit2", 32'(fwd_hit2), 32'h0);
      chk("rf_r5", rf_model[5], 32'hDEAD_BEEF);

      // Write to r0 is accepted and discarded
      @(negedge clk);
      src_valid = 3'b001;
      set_src(0, 5'd0, 32'h1234_5678);
      raddr1 = 5'd0;
      raddr2 = 5'd0;
      #1;
      chk("r0_ready", 32'(src_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("r0_wen", 32'(rf_wen), 32'h0);
      chk("r0_hit1", 32'(fwd_hit1), 32'h0);
      chk("r0_hit2", 32'(fwd_hit2), 32'h0);
      chk("r0_fwd1", fwd_data1, 32'h0);

      // Same-address collision serialised in grant order
      @(negedge clk);
      src_valid = 3'b011;
      set_src(0, 5'd7, 32'd1);
      set_src(1, 5'd7, 32'd2);
      raddr1 = 5'd7;
      #1;
      chk("coll_ready0", 32'(src_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("coll_wdata0", rf_wdata, 32'd1);
      chk("coll_fwd1_0", fwd_data1, 32'd1);
      @(negedge clk);
      src_valid = 3'b010;
      #1;
      chk("coll_ready1", 32'(src_ready), 32'h2);
      @(posedge clk);
      #1;
      chk("coll_wdata1", rf_wdata, 32'd2);
      chk("coll_waddr1", 32'(rf_waddr), 32'd7);
      @(negedge clk);
      src_valid = 3'b000;
      @(posedge clk);
      #1;
      chk("coll_rf_r7", rf_model[7], 32'd2);

      // src0 and src2 continuously valid
      @(negedge clk);
      set_src(0, 5'd9, 32'hA0A0_A0A0);
      set_src(2, 5'd10, 32'hC2C2_C2C2);
      src_valid = 3'b101;
      g0 = 0;
      g2 = 0;
`ifdef RF_WB_ARB_AGING_EN
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("aging_ready_c%0d", c), 32'(src_ready), (c < 4) ? 32'h1 : 32'h4);
         @(posedge clk);
         #1;
         chk($sformatf("aging_wen_c%0d", c), 32'(rf_wen), 32'h1);
         @(negedge clk);
      end
      chk("aging_waddr_last", 32'(rf_waddr), 32'd10);
      // src2 counter restarted: it must wait the full MAX_WAIT again
      src_valid = 3'b101;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (src_ready[2]) g2++;
         @(negedge clk);
      end
      chk("aging_second_src2", 32'(g2), 32'd1);
`else
      for (int c = 0; c < 20; c++) begin
         #1;
         if (src_ready[0]) g0++;
         if (src_ready[2]) g2++;
         @(posedge clk);
         #1;
         chk($sformatf("strict_wen_c%0d", c), 32'(rf_wen), 32'h1);
         @(negedge clk);
      end
      chk("strict_grants_src0", 32'(g0), 32'd20);
      chk("strict_grants_src2", 32'(g2), 32'd0);
      chk("strict_waddr", 32'(rf_waddr), 32'd9);
`endif
      src_valid = 3'b000;
      @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and sequencer for the 32×32 general-purpose register file. It shares the register file's single write port among NUM_SRC writeback requesters: the main pipeline WB stage, the multi-cycle multiply/divide unit and the CP0 move path. Each requester uses a valid/ready handshake. The block registers the winning write into the register file's `wen`/`waddr`/`wdata` inputs. It also forwards that in-flight write to the two read ports so readers never see stale data.

## Interface
Parameters:
- `NUM_SRC`, default 3: number of writeback requesters, range 2–8; index 0 has the highest base priority.
- `MAX_WAIT`, default 4: number of consecutive denied cycles after which a requester becomes starving, range 1–15.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `src_valid`, input, NUM_SRC: per-source write request.
- `src_ready`, output, NUM_SRC: per-source grant; combinational; at most one bit set.
- `src_waddr`, input, 5·NUM_SRC: destination register; source i occupies bits [5i+4:5i].
- `src_wdata`, input, 32·NUM_SRC: write data; source i occupies bits [32i+31:32i].
- `rf_wen`, output, 1: register file write enable, registered.
- `rf_waddr`, output, 5: register file write address, registered.
- `rf_wdata`, output, 32: register file write data, registered.
- `raddr1`, `raddr2`, input, 5: register file read addresses, snooped for forwarding.
- `fwd_hit1`, `fwd_hit2`, output, 1: the in-flight write matches the corresponding read address.
- `fwd_data1`, `fwd_data2`, output, 32: forwarded data; equals `rf_wdata` when the matching hit is set, otherwise 0.

## Operation
- **Transfer:** a transfer on source i occurs in a cycle where `src_valid[i] && src_ready[i]`.
- **Source obligations:** once `src_valid[i]` is asserted, source i holds it and holds its address and data stable until the transfer.
- **Grant selection:** the grant goes to the lowest-index starving valid source. If no valid source is starving, it goes to the lowest-index valid source. No valid source means no grant.
- **Wait counters:** each source has a wait counter `wait_cnt[i]`, 4 bits wide.
  - Cleared when source i is granted or `src_valid[i]` is 0.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Source i is starving when `wait_cnt[i] == MAX_WAIT`.
- **Output register:**
  - On a transfer: `rf_waddr` and `rf_wdata` load the source's address and data. `rf_wen` loads 1 if the address is nonzero, and 0 for a write to r0, which is accepted and discarded.
  - With no transfer: `rf_wen` loads 0, and `rf_waddr` and `rf_wdata` hold their values.
- **Forwarding:** `fwd_hitK = rf_wen && (rf_waddr == raddrK) && (raddrK != 0)`. This is purely combinational from the registered outputs.
- **Reset:** while `reset` is 1, `src_ready` is all zero. At the reset edge, `rf_wen`, `rf_waddr`, `rf_wdata` and all wait counters are cleared. Any request pending during reset is neither granted nor lost: it is granted after reset deasserts, provided the source still holds valid.

## Timing
- **Reset values:** `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `fwd_hit*=0`, `fwd_data*=0`; `src_ready=0` while `reset` is high.
- **Grant timing:** combinational, in the same cycle as `src_valid`. Zero-cycle grant when the source is the sole requester.
- **Write latency:** the write appears on the `rf_*` outputs one cycle after the transfer. It commits to the register file at the following edge, so it is visible from the register file two cycles after the transfer and via `fwd_*` one cycle after.
- **Throughput:** one write per cycle, sustained.
- **Wait bound:** with aging enabled and MAX_WAIT=M, a continuously valid source waits at most M + NUM_SRC − 1 cycles. In the worst case all sources become starving together and are served in index order.
- **Simultaneous events:** same-cycle requests from several sources to the same address are serialized in grant order. The later write wins in the register file.
- **Wait counters on reset:** an edge with `reset` high clears the counters regardless of valid.

## Configuration
- **Macro:** `RF_WB_ARB_AGING_EN`.
- **Defined:** the wait counters and starvation promotion operate as above.
- **Undefined:** the wait counters are not instantiated. Arbitration is strict fixed priority (lowest valid index wins), so a lower-priority source can starve indefinitely. MAX_WAIT is ignored. All other behaviour is identical.

## Test plan
- **Reset behaviour:** assert `reset` for 3 cycles with all `src_valid`=1 → `src_ready`=0 and `rf_wen`=0 throughout. On the first cycle after deassert, `src_ready`=3'b001.
- **Single write and forwarding:** src1 writes r5=32'hDEADBEEF alone → `src_ready[1]`=1 in the same cycle. Next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=DEADBEEF. With `raddr2`=5: `fwd_hit2`=1, `fwd_data2`=DEADBEEF.
- **r0 write:** src0 writes r0=32'h12345678 → the transfer completes (`src_ready[0]`=1). Next cycle `rf_wen`=0 and `fwd_hit*`=0 for `raddr`=0.
- **Aging enabled:** with MAX_WAIT=4, src0 is valid on every cycle and src2 is valid from cycle 0 → src0 is granted in cycles 0–3 and src2 in cycle 4. `wait_cnt[2]` is then cleared.
- **Aging disabled:** without the macro, same stimulus for 20 cycles → src2 is never granted and src0 gets 20 grants.
- **Same-address collision:** src0 writes r7=1 and src1 writes r7=2 in the same cycle → the `rf_*` outputs carry 1 then 2 on consecutive cycles. The final register file value is 2.
